data_ram: RTL and testbench



---
 rtl/data_ram.sv | 164 ++++++++++++++++
 tb/tb_data_ram.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// data_ram: byte-addressable data memory behind the core's MEM stage.
// Ports:
//   clk, rst           - clock; synchronous active-high reset
//   W_en, R_en         - store / load request (both set means store only)
//   ram_addr           - byte address; only the low ADDR_WIDTH+2 bits index the array
//   Wr_mem_data        - right-aligned store data
//   RW_type            - funct3 access type (B, H, W, BU, HU)
//   fault_clr          - clears the sticky fault state
//   Rd_mem_data        - combinational, extended load result (0 if no load)
//   misalign_fault     - sticky fault flag
//   fault_addr         - address of the first fault since the last clear
//   fault_is_store     - the first fault was a store
//   ld_cnt, st_cnt     - saturating counts of completed loads / stores
module data_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 W_en,
    input  logic                 R_en,
    input  logic [31:0]          ram_addr,
    input  logic [31:0]          Wr_mem_data,
    input  logic [2:0]           RW_type,
    input  logic                 fault_clr,
    output logic [31:0]          Rd_mem_data,
    output logic                 misalign_fault,
    output logic [31:0]          fault_addr,
    output logic                 fault_is_store,
    output logic [CNT_WIDTH-1:0] ld_cnt,
    output logic [CNT_WIDTH-1:0] st_cnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            off;
    logic                  valid;
    logic                  type_ok;
    logic                  uns;
    logic [1:0]            sz;
    logic                  misal;
    logic                  bad;
    logic                  store_ok;
    logic                  load_ok;
    logic [3:0]            be;
    logic [31:0]           wlanes;
    logic [31:0]           rd_word;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;

    // Upper address bits alias onto the array and are deliberately ignored.
    logic unused_hi;
    assign unused_hi = ^ram_addr[31:ADDR_WIDTH+2];

    assign idx   = ram_addr[ADDR_WIDTH+1:2];
    assign off   = ram_addr[1:0];
    assign valid = W_en | R_en;

    // sz: 0 = byte, 1 = half, 2 = word
    always_comb begin
        type_ok = 1'b1;
        uns     = 1'b0;
        sz      = 2'd0;
        case (RW_type)
            3'b000: sz = 2'd0;
            3'b001: sz = 2'd1;
            3'b010: sz = 2'd2;
            3'b100: begin sz = 2'd0; uns = 1'b1; end
            3'b101: begin sz = 2'd1; uns = 1'b1; end
            default: type_ok = 1'b0;
        endcase
    end

    assign misal = ((sz == 2'd1) && off[0]) ||
                   ((sz == 2'd2) && (off != 2'b00));

    // Unsigned types have no store form, so a store with BU/HU is bad.
    assign bad      = valid && (!type_ok || misal || (W_en && uns));
    assign store_ok = W_en && !bad;
    assign load_ok  = R_en && !W_en && !bad;

    always_comb begin
        case (sz)
            2'd0:    be = 4'b0001 << off;
            2'd1:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Replicate the right-aligned data so every lane sees its bytes.
    always_comb begin
        case (sz)
            2'd0:    wlanes = {4{Wr_mem_data[7:0]}};
            2'd1:    wlanes = {2{Wr_mem_data[15:0]}};
            default: wlanes = Wr_mem_data;
        endcase
    end

    // Array is not reset; reset only suppresses the store.
    always_ff @(posedge clk) begin
        if (!rst && store_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
                end
            end
        end
    end

    // Asynchronous read sees pre-write contents in a same-word write cycle.
    assign rd_word = mem[idx];

    always_comb begin
        byte_v      = rd_word[{off, 3'b000} +: 8];
        half_v      = off[1] ? rd_word[31:16] : rd_word[15:0];
        Rd_mem_data = 32'h0;
        if (load_ok) begin
            case (sz)
                2'd0:    Rd_mem_data = uns ? {24'h0, byte_v}
                                           : {{24{byte_v[7]}}, byte_v};
                2'd1:    Rd_mem_data = uns ? {16'h0, half_v}
                                           : {{16{half_v[15]}}, half_v};
                default: Rd_mem_data = rd_word;
            endcase
        end
    end

    // A fault in the same cycle as fault_clr wins and recaptures.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_fault <= 1'b0;
            fault_addr     <= 32'h0;
            fault_is_store <= 1'b0;
        end else if (bad) begin
            misalign_fault <= 1'b1;
            if (!misalign_fault || fault_clr) begin
                fault_addr     <= ram_addr;
                fault_is_store <= W_en;
            end
        end else if (fault_clr) begin
            misalign_fault <= 1'b0;
            fault_addr     <= 32'h0;
            fault_is_store <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt <= '0;
            st_cnt <= '0;
        end else begin
            if (store_ok && (st_cnt != '1)) begin
                st_cnt <= st_cnt + 1'b1;
            end
            if (load_ok && (ld_cnt != '1)) begin
                ld_cnt <= ld_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: randomized and directed bench for data_ram.
// Uses a byte-array reference model; ADDR_WIDTH=6, CNT_WIDTH=4.
module tb_data_ram;

    localparam int AW   = 6;
    localparam int CW   = 4;
    localparam int NBYT = 4 * (2 ** AW);
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          W_en;
    logic          R_en;
    logic [31:0]   ram_addr;
    logic [31:0]   Wr_mem_data;
    logic [2:0]    RW_type;
    logic          fault_clr;
    logic [31:0]   Rd_mem_data;
    logic          misalign_fault;
    logic [31:0]   fault_addr;
    logic          fault_is_store;
    logic [CW-1:0] ld_cnt;
    logic [CW-1:0] st_cnt;

    data_ram #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .W_en           (W_en),
        .R_en           (R_en),
        .ram_addr       (ram_addr),
        .Wr_mem_data    (Wr_mem_data),
        .RW_type        (RW_type),
        .fault_clr      (fault_clr),
        .Rd_mem_data    (Rd_mem_data),
        .misalign_fault (misalign_fault),
        .fault_addr     (fault_addr),
        .fault_is_store (fault_is_store),
        .ld_cnt         (ld_cnt),
        .st_cnt         (st_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [7:0]  mm [NBYT];
    logic        m_flag;
    logic [31:0] m_faddr;
    logic        m_fst;
    int          m_ld;
    int          m_st;
    logic [31:0] rd_seen;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] t);
        return 1 << t[1:0];
    endfunction

    function automatic logic access_bad(input logic we, input logic re,
                                        input logic [31:0] a,
                                        input logic [2:0] t);
        logic legal;
        legal = (t == 0) || (t == 1) || (t == 2) || (t == 4) || (t == 5);
        if (!(we || re)) return 1'b0;
        if (!legal) return 1'b1;
        if ((int'(a[1:0]) % size_of(t)) != 0) return 1'b1;
        return we && (t >= 4);
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] a,
                                             input logic [2:0] t);
        logic [31:0] v;
        int          n;
        n = size_of(t);
        v = 0;
        for (int k = 0; k < n; k++)
            v = v | (32'(mm[int'(a[7:0]) + k]) << (8 * k));
        if (t < 4 && n < 4 && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // One clock: drive at negedge, check read before the edge,
    // update the model at the edge and check registered outputs after.
    task automatic cyc(input logic r, input logic we, input logic re,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] t, input logic clr);
        logic        b;
        logic [31:0] exp_rd;
        @(negedge clk);
        rst = r; W_en = we; R_en = re; ram_addr = a;
        Wr_mem_data = d; RW_type = t; fault_clr = clr;
        b = access_bad(we, re, a, t);
        exp_rd = (re && !we && !b) ? load_val(a, t) : 32'h0;
        #1;
        rd_seen = Rd_mem_data;
        check("rd", Rd_mem_data, exp_rd);
        @(posedge clk);
        if (r) begin
            m_flag = 0; m_faddr = 0; m_fst = 0; m_ld = 0; m_st = 0;
        end else begin
            if (b) begin
                if (!m_flag || clr) begin
                    m_faddr = a; m_fst = we;
                end
                m_flag = 1;
            end else if (clr) begin
                m_flag = 0; m_faddr = 0; m_fst = 0;
            end
            if (we && !b) begin
                for (int k = 0; k < size_of(t); k++)
                    mm[int'(a[7:0]) + k] = d[8*k +: 8];
                if (m_st < CMAX) m_st++;
            end else if (re && !b) begin
                if (m_ld < CMAX) m_ld++;
            end
        end
        #1;
        check("flag", 32'(misalign_fault), 32'(m_flag));
        check("faddr", fault_addr, m_faddr);
        check("fst", 32'(fault_is_store), 32'(m_fst));
        check("ldc", 32'(ld_cnt), 32'(m_ld));
        check("stc", 32'(st_cnt), 32'(m_st));
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  t;
        logic        we;
        logic        re;
        rst = 1; W_en = 0; R_en = 0; ram_addr = 0;
        Wr_mem_data = 0; RW_type = 0; fault_clr = 0;
        m_flag = 0; m_faddr = 0; m_fst = 0; m_ld = 0; m_st = 0;
        rd_seen = 0;
        for (int i = 0; i < NBYT; i++) mm[i] = 8'h00;

        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int w = 0; w < NBYT / 4; w++)
            cyc(0, 1, 0, 32'(w * 4), $urandom, 3'd2, 0);
        // reset keeps array contents
        cyc(1, 0, 0, 0, 0, 0, 0);

        // write then read
        cyc(0, 1, 0, 32'h10, 32'h8040_20FF, 3'd2, 0);
        cyc(0, 0, 1, 32'h10, 0, 3'd2, 0);
        check("lw10", rd_seen, 32'h8040_20FF);
        cyc(0, 0, 1, 32'h13, 0, 3'd0, 0);
        check("lb13", rd_seen, 32'hFFFF_FF80);
        cyc(0, 0, 1, 32'h13, 0, 3'd4, 0);
        check("lbu13", rd_seen, 32'h0000_0080);
        cyc(0, 0, 1, 32'h12, 0, 3'd1, 0);
        check("lh12", rd_seen, 32'hFFFF_8040);
        cyc(0, 0, 1, 32'h10, 0, 3'd5, 0);
        check("lhu10", rd_seen, 32'h0000_20FF);
        check("ld5", 32'(ld_cnt), 32'd5);
        check("st1", 32'(st_cnt), 32'd1);

        // byte lanes
        cyc(0, 1, 0, 32'h20, 32'h1122_3344, 3'd2, 0);
        cyc(0, 1, 0, 32'h21, 32'h0000_00AA, 3'd0, 0);
        cyc(0, 1, 0, 32'h22, 32'h0000_BEEF, 3'd1, 0);
        cyc(0, 0, 1, 32'h20, 0, 3'd2, 0);
        check("lanes", rd_seen, 32'hBEEF_AA44);

        // misalignment, first fault sticks
        cyc(0, 1, 0, 32'h31, 32'hDEAD_BEEF, 3'd2, 0);
        check("mf", 32'(misalign_fault), 32'd1);
        check("mfa", fault_addr, 32'h31);
        check("mfs", 32'(fault_is_store), 32'd1);
        cyc(0, 0, 1, 32'h45, 0, 3'd1, 0);
        check("lh45", rd_seen, 32'h0);
        check("mfa2", fault_addr, 32'h31);
        cyc(0, 0, 1, 32'h30, 0, 3'd2, 0);

        // clear collides with new fault
        cyc(0, 0, 1, 32'h06, 0, 3'd2, 1);
        check("cf", 32'(misalign_fault), 32'd1);
        check("cfa", fault_addr, 32'h06);
        check("cfs", 32'(fault_is_store), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("clr", {fault_addr[30:0], misalign_fault}, 32'd0);

        // same-cycle read/write
        cyc(0, 1, 0, 32'h40, 32'h0, 3'd2, 0);
        cyc(0, 1, 1, 32'h40, 32'h5555_5555, 3'd2, 0);
        check("rw", rd_seen, 32'h0);
        cyc(0, 0, 1, 32'h40, 0, 3'd2, 0);
        check("rw2", rd_seen, 32'h5555_5555);

        // saturation, then reset with a store
        for (int i = 0; i < 17; i++) cyc(0, 0, 1, 32'h40, 0, 3'd2, 0);
        check("sat", 32'(ld_cnt), 32'hF);
        cyc(0, 1, 0, 32'h41, 0, 3'd2, 0);
        cyc(1, 1, 0, 32'h40, 32'h1, 3'd2, 0);
        check("rstc", {ld_cnt, st_cnt}, 32'h0);
        check("rstf", 32'(misalign_fault), 32'd0);
        cyc(0, 0, 1, 32'h40, 0, 3'd2, 0);
        check("keep", rd_seen, 32'h5555_5555);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            t = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) t = 3'($urandom_range(0, 2));
            we = ($urandom_range(0, 2) == 0);
            re = ($urandom_range(0, 1) == 0);
            cyc(($urandom_range(0, 60) == 0), we, re, a, $urandom, t,
                ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
